// File: rtl/instr_prefetch.sv
// instr_prefetch: byte-wide instruction prefetch buffer with fetch redirect.
//   clk         - single clock, all state on rising edge
//   resetN      - synchronous active-low reset
//   memAddr     - program memory read address (fetchAddr)
//   memStrobe   - read request; memDataRead is valid the following cycle
//   memDataRead - returned instruction byte
//   byteValid   - head of buffer holds a byte
//   byteData    - head instruction byte
//   bytePc      - address the head byte was fetched from
//   byteTake    - consumer pops the head at the edge
//   jumpEn      - redirect the fetch stream to jumpAddr
//   jumpAddr    - redirect target
module instr_prefetch #(
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
    input  logic                  clk,
    input  logic                  resetN,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic                  memStrobe,
    input  logic [7:0]            memDataRead,
    output logic                  byteValid,
    output logic [7:0]            byteData,
    output logic [ADDR_WIDTH-1:0] bytePc,
    input  logic                  byteTake,
    input  logic                  jumpEn,
    input  logic [ADDR_WIDTH-1:0] jumpAddr
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_WIDTH-1:0] fetch_q, fetch_d, tag_q, tag_d;
    logic                  inflight_q, inflight_d;
    logic [PW-1:0]         rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [7:0]            data_q [DEPTH];
    logic [ADDR_WIDTH-1:0] pc_q [DEPTH];
    logic [CW:0]           occ;
    logic                  room, issue, push, pop;

    // Occupancy counts the outstanding read so a returning byte always has a slot.
    assign occ       = {1'b0, cnt_q} + {{CW{1'b0}}, inflight_q};
    assign room      = occ < (CW+1)'(DEPTH);
    assign memStrobe = !resetN || room;
    assign memAddr   = resetN ? fetch_q : RESET_ADDR;
    assign byteValid = resetN && (cnt_q != '0);
    assign byteData  = data_q[rd_q];
    assign bytePc    = pc_q[rd_q];

    // A jump squashes the returning read, the pop and any issue in that cycle.
    assign issue = room && !jumpEn;
    assign push  = inflight_q && !jumpEn;
    assign pop   = byteTake && (cnt_q != '0) && !jumpEn;

    always_comb begin
        fetch_d    = jumpEn ? jumpAddr : (room ? fetch_q + ADDR_WIDTH'(1) : fetch_q);
        inflight_d = issue;
        tag_d      = issue ? fetch_q : tag_q;
        wr_d       = jumpEn ? '0 : wr_q + PW'(push);
        rd_d       = jumpEn ? '0 : rd_q + PW'(pop);
        cnt_d      = jumpEn ? '0 : cnt_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            fetch_q    <= RESET_ADDR;
            tag_q      <= RESET_ADDR;
            inflight_q <= 1'b0;
            rd_q       <= '0;
            wr_q       <= '0;
            cnt_q      <= '0;
        end else begin
            fetch_q    <= fetch_d;
            tag_q      <= tag_d;
            inflight_q <= inflight_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            cnt_q      <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (resetN && push) begin
            data_q[wr_q] <= memDataRead;
            pc_q[wr_q]   <= tag_q;
        end
    end
endmodule

// File: tb/tb_instr_prefetch.sv
// tb_instr_prefetch: directed and random checks of instr_prefetch (DEPTH 4 and 8).
module tb_instr_prefetch;
    logic       clk = 1'b0;
    logic       resetN, byteTake, jumpEn;
    logic [7:0] jumpAddr;
    logic [7:0] a4, r4, d4, p4, a8, r8, d8, p8;
    logic       s4, v4, s8, v8;
    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] exp_pc;

    always #5 clk = ~clk;

    instr_prefetch #(.ADDR_WIDTH(8), .DEPTH(4), .RESET_ADDR(8'h00)) u4 (
        .clk(clk), .resetN(resetN), .memAddr(a4), .memStrobe(s4), .memDataRead(r4),
        .byteValid(v4), .byteData(d4), .bytePc(p4), .byteTake(byteTake),
        .jumpEn(jumpEn), .jumpAddr(jumpAddr));

    instr_prefetch #(.ADDR_WIDTH(8), .DEPTH(8), .RESET_ADDR(8'h00)) u8 (
        .clk(clk), .resetN(resetN), .memAddr(a8), .memStrobe(s8), .memDataRead(r8),
        .byteValid(v8), .byteData(d8), .bytePc(p8), .byteTake(byteTake),
        .jumpEn(jumpEn), .jumpAddr(jumpAddr));

    function automatic logic [7:0] memval(input logic [7:0] a);
        case (a)
            8'h00: return 8'h31;
            8'h01: return 8'hC2;
            8'h02: return 8'h58;
            8'h03: return 8'hFF;
            default: return 8'(a * 13 + 5);
        endcase
    endfunction

    always @(posedge clk) begin
        if (s4) r4 <= memval(a4);
        if (s8) r8 <= memval(a8);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetN = 1'b0; byteTake = 1'b0; jumpEn = 1'b0; jumpAddr = 8'h00;
        step();
        step();
        check("rst_valid", 32'(v4), 32'd0);
        check("rst_strobe", 32'(s4), 32'd1);
        check("rst_addr", 32'(a4), 32'h00);
        resetN = 1'b1;
        // fill from reset with no consumer
        for (int i = 0; i < 4; i++) begin
            check("fill_strobe", 32'(s4), 32'd1);
            check("fill_addr", 32'(a4), 32'(i));
            check("fill_valid", 32'(v4), 32'(i >= 2));
            step();
        end
        check("full_strobe", 32'(s4), 32'd0);
        step();
        check("full_strobe2", 32'(s4), 32'd0);
        check("full_pc", 32'(p4), 32'h00);
        check("full_data", 32'(d4), 32'h31);
        // continuous consumption, no bubbles
        byteTake = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            check("stream_valid", 32'(v4), 32'd1);
            check("stream_pc", 32'(p4), 32'(k));
            check("stream_data", 32'(d4), 32'(memval(8'(k))));
        end
        // jump to FE, address wrap
        byteTake = 1'b0; jumpEn = 1'b1; jumpAddr = 8'hFE;
        step();
        jumpEn = 1'b0; byteTake = 1'b1;
        check("jfe_valid0", 32'(v4), 32'd0);
        check("jfe_strobe", 32'(s4), 32'd1);
        check("jfe_addr", 32'(a4), 32'hFE);
        step();
        check("jfe_valid1", 32'(v4), 32'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            check("jfe_v", 32'(v4), 32'd1);
            check("jfe_pc", 32'(p4), 32'(8'(8'hFE + k)));
            check("jfe_data", 32'(d4), 32'(memval(8'(8'hFE + k))));
        end
        // full buffer 00..03, then jump with take
        byteTake = 1'b0; jumpEn = 1'b1; jumpAddr = 8'h00;
        step();
        jumpEn = 1'b0;
        repeat (6) step();
        check("j0_full_strobe", 32'(s4), 32'd0);
        check("j0_full_pc", 32'(p4), 32'h00);
        jumpEn = 1'b1; jumpAddr = 8'h40; byteTake = 1'b1;
        step();
        jumpEn = 1'b0;
        check("j40_valid0", 32'(v4), 32'd0);
        check("j40_addr", 32'(a4), 32'h40);
        check("j40_strobe", 32'(s4), 32'd1);
        step();
        check("j40_valid1", 32'(v4), 32'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            check("j40_v", 32'(v4), 32'd1);
            check("j40_pc", 32'(p4), 32'(8'h40 + k));
            check("j40_data", 32'(d4), 32'(memval(8'(8'h40 + k))));
        end
        // back-to-back jumps
        byteTake = 1'b0; jumpEn = 1'b1; jumpAddr = 8'h10;
        step();
        jumpAddr = 8'h20;
        step();
        jumpEn = 1'b0;
        check("bb_addr", 32'(a4), 32'h20);
        step();
        step();
        check("bb_valid", 32'(v4), 32'd1);
        check("bb_pc", 32'(p4), 32'h20);
        // mid-stream reset with 3 bytes buffered
        jumpEn = 1'b1; jumpAddr = 8'h80;
        step();
        jumpEn = 1'b0;
        repeat (4) step();
        check("mr_pre_pc", 32'(p4), 32'h80);
        resetN = 1'b0;
        #1;
        check("mr_in_valid", 32'(v4), 32'd0);
        step();
        resetN = 1'b1;
        check("mr_valid0", 32'(v4), 32'd0);
        check("mr_addr", 32'(a4), 32'h00);
        check("mr_strobe", 32'(s4), 32'd1);
        step();
        check("mr_valid1", 32'(v4), 32'd0);
        step();
        check("mr_valid2", 32'(v4), 32'd1);
        check("mr_pc", 32'(p4), 32'h00);
        check("mr_data", 32'(d4), 32'h31);
        // DEPTH=8: random take and jumps against an in-order stream model
        resetN = 1'b0;
        step();
        resetN = 1'b1;
        exp_pc = 8'h00;
        for (int c = 0; c < 400; c++) begin
            byteTake = 1'($urandom_range(0, 1));
            jumpEn = ($urandom_range(0, 19) == 0);
            jumpAddr = 8'($urandom);
            if (jumpEn) exp_pc = jumpAddr;
            else if (byteTake && v8) begin
                check("rnd_pc", 32'(p8), 32'(exp_pc));
                check("rnd_data", 32'(d8), 32'(memval(exp_pc)));
                exp_pc = exp_pc + 8'd1;
            end
            step();
        end
        jumpEn = 1'b0; byteTake = 1'b0;
        for (int w = 0; w < 20 && !v8; w++) step();
        check("drain_valid", 32'(v8), 32'd1);
        check("drain_pc", 32'(p8), 32'(exp_pc));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_prefetch.md
INSTR_PREFETCH -- requirements
Module: instr_prefetch

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 8, the width of the program address.
REQ-002 The block SHALL have parameter DEPTH, default 4, the byte-buffer entries, a power of two and at least 4.
REQ-003 The block SHALL have parameter RESET_ADDR, default 0, the first fetch address after reset.
REQ-004 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 Port resetN, input, 1: the reset, synchronous and active-low.
REQ-006 Port memAddr, output, ADDR_WIDTH: the read address to program memory.
REQ-007 Port memStrobe, output, 1: the read request; memory returns memDataRead on the following cycle.
REQ-008 Port memDataRead, input, 8: the read data, valid the cycle after memStrobe.
REQ-009 Port byteValid, output, 1: the head entry of the buffer is valid.
REQ-010 Port byteData, output, 8: the head entry's instruction byte.
REQ-011 Port bytePc, output, ADDR_WIDTH: the address the head byte was fetched from.
REQ-012 Port byteTake, input, 1: the consumer pops the head at the edge.
REQ-013 Port jumpEn, input, 1: redirect the fetch stream.
REQ-014 Port jumpAddr, input, ADDR_WIDTH: the redirect target.

Function
REQ-015 State SHALL comprise: fetchAddr (ADDR_WIDTH); inFlight (1 bit); a circular buffer of DEPTH entries {data, pc} with read pointer, write pointer and count (0..DEPTH).
REQ-016 memAddr SHALL equal fetchAddr.
REQ-017 memStrobe SHALL be 1 exactly when count + inFlight < DEPTH; it is decoded from registers only, with no combinational path from byteTake or jumpEn.
REQ-018 Issue: on an edge with memStrobe=1 and jumpEn=0, the block SHALL set inFlight to 1, latch the tag pc=fetchAddr, and increment fetchAddr modulo 2^ADDR_WIDTH (0xFF wraps to 0x00).
REQ-019 Issue: on an edge with memStrobe=0 and jumpEn=0, inFlight SHALL go to 0 and fetchAddr SHALL hold.
REQ-020 Push: on an edge with inFlight=1 and jumpEn=0, the block SHALL write {memDataRead, tag} at the write pointer.
REQ-021 Pop: on an edge with byteTake=1, byteValid=1 and jumpEn=0, the block SHALL advance the read pointer.
REQ-022 A byteTake with byteValid=0 SHALL be ignored.
REQ-023 A simultaneous push and pop SHALL leave count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-024 byteValid SHALL be (count != 0); byteData and bytePc SHALL be the head entry, undefined-but-stable when byteValid=0.
REQ-025 Latency: a strobe in cycle t SHALL make the byte visible at the head no earlier than cycle t+2 (byteValid=1 in t+2 when the buffer was empty).
REQ-026 Throughput: with byteTake held at 1, the block SHALL sustain one byte per cycle, with no bubble after the pipeline fills.
REQ-027 Full: at count + inFlight = DEPTH, strobes SHALL stop; no entry is ever overwritten and no returned byte is ever dropped.
REQ-028 Redirect: on an edge with jumpEn=1, the block SHALL set count=0, reset both pointers, set inFlight=0 and set fetchAddr=jumpAddr.
REQ-029 A read returning during the jump cycle, or issued in the jump cycle, SHALL be discarded.
REQ-030 jumpEn SHALL override byteTake, push and issue in the same cycle.
REQ-031 After a jump at edge e, the first strobe SHALL be at jumpAddr in the cycle after e, and byteValid SHALL rise 2 cycles later with bytePc=jumpAddr.
REQ-032 Back-to-back jumps SHALL each restart from the newest jumpAddr.

Reset
REQ-033 On an edge with resetN=0, the block SHALL set fetchAddr=RESET_ADDR, inFlight=0, count=0 and pointers=0, overriding jumpEn and byteTake.
REQ-034 During reset, memStrobe SHALL read 1 and memAddr SHALL read RESET_ADDR, but nothing SHALL be issued; byteValid SHALL be 0.
REQ-035 A reset asserted mid-stream SHALL discard all buffered and in-flight bytes.

Verification
REQ-036 Bench: release reset, mem[0..3]=31,C2,58,FF, byteTake=0 -> strobes at addresses 0,1,2,3; then memStrobe=0; byteValid from cycle 2; head 31/pc 00; count=4.
REQ-037 Bench: byteTake=1 continuously over a linear program -> one byte per cycle with bytePc 00,01,02,...; no gaps after the first valid.
REQ-038 Bench: ADDR_WIDTH=8, jump to FE, stream 4 bytes -> bytePc FE,FF,00,01.
REQ-039 Bench: buffer full with 00..03, jumpEn=1, jumpAddr=40, together with byteTake=1 -> byteValid=0 next cycle; next head is pc 40 with mem[40]; no byte from 00..04 appears after the jump.
REQ-040 Bench: resetN=0 for one cycle mid-stream with 3 bytes buffered -> byteValid=0; fetch restarts at RESET_ADDR.
REQ-041 Bench: DEPTH=8 random byteTake and random jumps against a reference queue model -> byte order and pc tags match, with no overflow.
